regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Owns the single regfile write port (rfwe/rfwa/rfwd) and shares it between two writers: the in-order pipeline writeback (WB) and the long-latency unit (LLU, mul/div).
- LLU results wait in a small FIFO and drain only on cycles when WB leaves the port idle.
- A per-register pending scoreboard stalls decode on RAW/WAW hazards against in-flight LLU results.
- Sits between the WB stage, the LLU and regfile.

Parameters:
- FIFO_DEPTH, 2, LLU result buffer entries; power of two, >=2.
- NUM_REG, 32 (package constant), architectural register count.

Ports:
- cpu_clk_50M  in  1  clock
- cpu_rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  WB write request
- wb_wa  in  reg_enum(5)  WB destination
- wb_wd  in  word_t(32)  WB data
- llu_issue  in  1  decode issues an LLU op this cycle
- llu_issue_wa  in  reg_enum(5)  its destination
- llu_valid  in  1  LLU result valid
- llu_wa  in  reg_enum(5)  result destination
- llu_wd  in  word_t(32)  result data
- llu_ready  out  1  FIFO can accept
- dec_re1, dec_re2  in  1 each  decode read enables
- dec_ra1, dec_ra2  in  reg_enum(5) each  decode read addresses
- dec_we  in  1  decode instruction writes a register
- dec_wa  in  reg_enum(5)  its destination
- stall  out  1  hold decode
- pending  out  NUM_REG  scoreboard bits (debug/visibility)
- rfwe  out  1  to regfile
- rfwa  out  reg_enum(5)  to regfile
- rfwd  out  word_t(32)  to regfile

Behaviour:
- Reset (cpu_rst_n low, async):
  - FIFO emptied; pending = 0.
  - rfwe = 0, rfwa = REG_ZERO, rfwd = ZERO; stall = 0; llu_ready = 0.
  - Reset mid-operation discards all buffered results and pending bits; no write reaches regfile.
- Write-port priority:
  - WB is "active" when wb_we && wb_wa != REG_ZERO. WB always wins and is never stalled: rfwe = 1, rfwa = wb_wa, rfwd = wb_wd, combinational (zero latency).
  - Otherwise, if the FIFO is non-empty, the head drives the port (rfwe = 1, head addr/data) and is popped at the clock edge.
  - Otherwise rfwe = 0, rfwa = REG_ZERO, rfwd = ZERO.
- LLU handshake:
  - Transfer occurs when llu_valid && llu_ready.
  - llu_ready = !full, evaluated on registered state (no combinational dependency on pop).
  - A result with llu_wa == REG_ZERO is accepted and discarded (never enqueued).
  - Push and pop in the same cycle are legal. When full, a pop does not raise llu_ready until the next cycle.
- FIFO: read/write pointers with wrap-around at FIFO_DEPTH; count in 0..FIFO_DEPTH; ordering strictly FIFO.
- Scoreboard:
  - pending[r] is set at the edge when llu_issue && !stall && llu_issue_wa == r && r != REG_ZERO.
  - pending[r] is cleared at the edge when the FIFO head for r is written to regfile.
  - If set and clear hit the same r in the same cycle, set wins.
  - pending[REG_ZERO] is constantly 0.
- Stall (combinational from registered pending):
  - stall = (dec_re1 && pending[dec_ra1]) || (dec_re2 && pending[dec_ra2]) || (dec_we && pending[dec_wa]) || (llu_issue && pending[llu_issue_wa]).
  - No bypass: a register becomes readable the cycle after its drain write.
- Issue while the FIFO is full is legal; back-pressure is applied only to the LLU.
- Assertion targets for verification:
  - An LLU result whose pending bit is clear.
  - FIFO overflow.
  - WB write to a pending register.

Decomposition:
- mips_cpu_pkg (shared): reg_enum, word_t, ZERO, REG_ZERO, NUM_REG, plus new LLU_FIFO_DEPTH default.
- One natural sub-module: llu_result_fifo (parameterised sync FIFO, async reset, push/pop/full/empty, head outputs) instantiated once; scoreboard and priority mux stay in the top.

Test Plan:
- Reset mid-drain: FIFO holds 2 results, assert cpu_rst_n=0 -> rfwe=0, pending=0, llu_ready=0 immediately; after release, no stale write occurs.
- WB priority: llu_valid with r5=0x11111111 while wb_we writes r3=0x22222222 for 3 cycles -> regfile gets r3 each cycle; r5 written on the first WB-idle cycle; pending[5] clears the following cycle.
- RAW stall: issue LLU to r8, then decode reads r8 (dec_re1, dec_ra1=8) -> stall=1 until the cycle after r8 drains; then stall=0 and regfile read returns the LLU data.
- Full back-pressure: FIFO_DEPTH=2, WB busy every cycle, 3 LLU results -> llu_ready=0 after 2 accepts; when WB idles, results drain in order and the third is accepted one cycle after the first pop.
- REG_ZERO: issue and result with wa=REG_ZERO -> pending unchanged, rfwe never asserted for it, stall=0.
- WAW: pending[12] set, decode with dec_we=1, dec_wa=12 -> stall=1; wb_wa=REG_ZERO with wb_we=1 is treated as idle, so the FIFO drains that cycle.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: register names, data word, LLU result record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_cpu_pkg;

   localparam int NUM_REG        = 32;
   localparam int LLU_FIFO_DEPTH = 2;

   typedef logic [31:0] word_t;
   localparam word_t ZERO = '0;

   typedef enum logic [4:0] {
      REG_ZERO = 5'd0, REG_AT, REG_V0, REG_V1,
      REG_A0, REG_A1, REG_A2, REG_A3,
      REG_T0, REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
      REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
      REG_T8, REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
   } reg_enum;

   // One buffered LLU result: destination register and value.
   typedef struct packed {
      reg_enum wa;
      word_t   wd;
   } llu_res_t;

   // One-hot select of a register in a NUM_REG-wide bit vector.
   function automatic logic [NUM_REG-1:0] reg_onehot(input reg_enum r);
      return NUM_REG'(1) << r;
   endfunction

endpackage

// File: rtl/llu_result_fifo.sv
// Small synchronous FIFO holding LLU results until the regfile port is free.
// Latency: push visible at head the cycle after the push edge; pop takes effect at the edge.
// Backpressure: full_o/empty_o from registered count; push when full and pop when empty are ignored.
module llu_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_dat_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign head_dat_o = mem_q[rd_ptr_q];

   // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer, count and storage registers; reset drops every buffered entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
      else $error("llu_result_fifo overflow");
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between WB (priority) and buffered LLU results; tracks LLU-pending regs.
// Latency: WB write is combinational; an LLU result drains the cycle after acceptance at the earliest.
// Backpressure: llu_ready = !full on registered state; decode stalled on hazards; WB never stalled.
module regfile_wr_arbiter
   import mips_cpu_pkg::*;
#(
   parameter int FIFO_DEPTH = LLU_FIFO_DEPTH
) (
   input  logic               cpu_clk_50M,
   input  logic               cpu_rst_n,
   input  logic               wb_we,
   input  reg_enum            wb_wa,
   input  word_t              wb_wd,
   input  logic               llu_issue,
   input  reg_enum            llu_issue_wa,
   input  logic               llu_valid,
   input  reg_enum            llu_wa,
   input  word_t              llu_wd,
   output logic               llu_ready,
   input  logic               dec_re1,
   input  logic               dec_re2,
   input  reg_enum            dec_ra1,
   input  reg_enum            dec_ra2,
   input  logic               dec_we,
   input  reg_enum            dec_wa,
   output logic               stall,
   output logic [NUM_REG-1:0] pending,
   output logic               rfwe,
   output reg_enum            rfwa,
   output word_t              rfwd
);

   logic [NUM_REG-1:0] pending_q, pending_d;
   logic [NUM_REG-1:0] set_vec, clr_vec;
   llu_res_t           push_res, head_res;
   logic [$bits(llu_res_t)-1:0] head_raw;
   logic               fifo_full, fifo_empty;
   logic               wb_act, drain, push;

   // A WB write to r0 is architecturally a no-op, so it leaves the port free for the FIFO.
   assign wb_act    = wb_we && (wb_wa != REG_ZERO);
   assign llu_ready = cpu_rst_n && !fifo_full;
   assign drain     = cpu_rst_n && !wb_act && !fifo_empty;
   // r0 results are acknowledged but never buffered.
   assign push      = llu_valid && llu_ready && (llu_wa != REG_ZERO);

   assign push_res.wa = llu_wa;
   assign push_res.wd = llu_wd;
   assign head_res    = llu_res_t'(head_raw);

   llu_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(llu_res_t))
   ) u_fifo (
      .clk_i      (cpu_clk_50M),
      .rst_ni     (cpu_rst_n),
      .push_i     (push),
      .push_dat_i (push_res),
      .pop_i      (drain),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_dat_o (head_raw)
   );

   // Write-port mux: WB first, then FIFO head, else idle; forced idle while in reset.
   always_comb begin
      rfwe = 1'b0;
      rfwa = REG_ZERO;
      rfwd = ZERO;
      if (cpu_rst_n) begin
         if (wb_act) begin
            rfwe = 1'b1;
            rfwa = wb_wa;
            rfwd = wb_wd;
         end else if (!fifo_empty) begin
            rfwe = 1'b1;
            rfwa = head_res.wa;
            rfwd = head_res.wd;
         end
      end
   end

   // Hazard check uses only registered pending bits, so there is no bypass from a drain write.
   assign stall = (dec_re1   && pending_q[dec_ra1])
               || (dec_re2   && pending_q[dec_ra2])
               || (dec_we    && pending_q[dec_wa])
               || (llu_issue && pending_q[llu_issue_wa]);

   // Scoreboard update: issue sets, drain clears, set wins on a collision; r0 never pending.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (llu_issue && !stall && (llu_issue_wa != REG_ZERO)) set_vec = reg_onehot(llu_issue_wa);
      if (drain) clr_vec = reg_onehot(head_res.wa);
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      pending_d[0] = 1'b0;
   end

   // Pending scoreboard register.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) pending_q <= '0;
      else            pending_q <= pending_d;
   end

   assign pending = pending_q;

`ifndef SYNTHESIS
   a_result_pending: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
      (llu_valid && llu_ready && (llu_wa != REG_ZERO)) |-> pending_q[llu_wa])
      else $error("LLU result for a register that is not pending");
   a_wb_not_pending: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
      wb_act |-> !pending_q[wb_wa])
      else $error("WB write to a register with an LLU result in flight");
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random legal traffic vs a queue-based model.
// Latency: inputs change 1 time unit after posedge, outputs compared 1 unit later.
// Backpressure: LLU results held until accepted; WB never targets a pending register.
module tb_regfile_wr_arbiter;
   import mips_cpu_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic cpu_rst_n;
   logic wb_we, llu_issue, llu_valid, dec_re1, dec_re2, dec_we;
   reg_enum wb_wa, llu_issue_wa, llu_wa, dec_ra1, dec_ra2, dec_wa;
   word_t wb_wd, llu_wd;
   logic llu_ready, stall, rfwe;
   logic [NUM_REG-1:0] pending;
   reg_enum rfwa;
   word_t rfwd;

   regfile_wr_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .cpu_clk_50M(clk), .cpu_rst_n(cpu_rst_n),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .llu_issue(llu_issue), .llu_issue_wa(llu_issue_wa),
      .llu_valid(llu_valid), .llu_wa(llu_wa), .llu_wd(llu_wd), .llu_ready(llu_ready),
      .dec_re1(dec_re1), .dec_re2(dec_re2), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
      .dec_we(dec_we), .dec_wa(dec_wa), .stall(stall), .pending(pending),
      .rfwe(rfwe), .rfwa(rfwa), .rfwd(rfwd)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending set, in-order result queue, and LLU ops in flight.
   typedef struct packed {
      logic [4:0] wa;
      word_t      wd;
   } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pend = '0;
   logic        m_stall = 1'b0;
   logic        m_acc   = 1'b0;
   logic [4:0]  outs[$];

   task automatic idle();
      wb_we = 0; wb_wa = REG_ZERO; wb_wd = '0;
      llu_issue = 0; llu_issue_wa = REG_ZERO;
      llu_valid = 0; llu_wa = REG_ZERO; llu_wd = '0;
      dec_re1 = 0; dec_re2 = 0; dec_we = 0;
      dec_ra1 = REG_ZERO; dec_ra2 = REG_ZERO; dec_wa = REG_ZERO;
   endtask

   // Compare all outputs against the model for the current inputs, then advance one clock.
   task automatic step();
      logic       wb_act, pop, exp_we, exp_ready;
      logic [4:0] exp_wa;
      word_t      exp_wd;
      #1;
      wb_act    = wb_we && (wb_wa != REG_ZERO);
      exp_ready = (m_q.size() < DEPTH);
      m_stall   = (dec_re1 && m_pend[dec_ra1]) || (dec_re2 && m_pend[dec_ra2])
               || (dec_we && m_pend[dec_wa]) || (llu_issue && m_pend[llu_issue_wa]);
      if (wb_act) begin
         exp_we = 1; exp_wa = wb_wa; exp_wd = wb_wd;
      end else if (m_q.size() > 0) begin
         exp_we = 1; exp_wa = m_q[0].wa; exp_wd = m_q[0].wd;
      end else begin
         exp_we = 0; exp_wa = '0; exp_wd = '0;
      end
      check("rfwe", rfwe, exp_we);
      check("rfwa", rfwa, exp_wa);
      check("rfwd", rfwd, exp_wd);
      check("stall", stall, m_stall);
      check("llu_ready", llu_ready, exp_ready);
      check("pending", pending, m_pend);
      pop   = !wb_act && (m_q.size() > 0);
      m_acc = llu_valid && exp_ready;
      @(posedge clk);
      if (pop) begin
         m_pend[m_q[0].wa] = 1'b0;
         void'(m_q.pop_front());
      end
      if (m_acc && llu_wa != REG_ZERO) m_q.push_back('{wa: llu_wa, wd: llu_wd});
      if (llu_issue && !m_stall && llu_issue_wa != REG_ZERO) m_pend[llu_issue_wa] = 1'b1;
      #1;
   endtask

   task automatic issue(input reg_enum r);
      idle(); llu_issue = 1; llu_issue_wa = r; step();
   endtask

   task automatic apply_reset();
      cpu_rst_n = 0;
      #1;
      check("rst_rfwe", rfwe, 0);
      check("rst_rfwa", rfwa, REG_ZERO);
      check("rst_rfwd", rfwd, 0);
      check("rst_pending", pending, 0);
      check("rst_ready", llu_ready, 0);
      check("rst_stall", stall, 0);
      m_q.delete(); outs.delete(); m_pend = '0; m_acc = 0;
      @(posedge clk); #1;
      idle();
      cpu_rst_n = 1;
   endtask

   initial begin
      idle();
      wb_we = 1; wb_wa = REG_V0; wb_wd = 32'hDEAD0000;
      apply_reset();

      // WB priority over a buffered LLU result.
      issue(REG_A1);
      idle(); wb_we = 1; wb_wa = REG_V1; wb_wd = 32'h22222222;
      llu_valid = 1; llu_wa = REG_A1; llu_wd = 32'h11111111;
      step();
      llu_valid = 0; step(); step();
      idle(); #1;
      check("wbp_drain_wa", rfwa, REG_A1);
      check("wbp_drain_wd", rfwd, 32'h11111111);
      step(); #1;
      check("wbp_pend5_clear", pending[5], 0);
      step();

      // RAW stall until the cycle after the drain write.
      issue(REG_T0);
      idle(); dec_re1 = 1; dec_ra1 = REG_T0; #1;
      check("raw_stall", stall, 1);
      step(); step();
      llu_valid = 1; llu_wa = REG_T0; llu_wd = 32'hCAFEF00D; step();
      llu_valid = 0; step();
      #1; check("raw_release", stall, 0);
      step();

      // Full back-pressure with WB busy, then in-order drain.
      issue(REG_AT); issue(REG_V0); issue(REG_A0);
      idle(); wb_we = 1; wb_wa = REG_S0; wb_wd = 32'h5;
      llu_valid = 1; llu_wa = REG_AT; llu_wd = 32'hA1; step();
      llu_wa = REG_V0; llu_wd = 32'hA2; step();
      llu_wa = REG_A0; llu_wd = 32'hA4; #1;
      check("bp_full_ready", llu_ready, 0);
      step(); step();
      wb_we = 0; #1;
      check("bp_ready_during_pop", llu_ready, 0);
      step(); #1;
      check("bp_ready_after_pop", llu_ready, 1);
      step();
      llu_valid = 0; step(); step(); step();

      // r0 destinations never become pending or written.
      idle(); llu_issue = 1; llu_issue_wa = REG_ZERO; dec_re1 = 1; step();
      idle(); llu_valid = 1; llu_wa = REG_ZERO; llu_wd = 32'h77; step();
      idle(); #1;
      check("zero_rfwe", rfwe, 0);
      check("zero_pend", pending, 0);
      step();

      // WAW stall; WB to r0 counts as idle so the FIFO drains.
      issue(REG_T4);
      idle(); wb_we = 1; wb_wa = REG_S1; llu_valid = 1; llu_wa = REG_T4; llu_wd = 32'h1234; step();
      idle(); dec_we = 1; dec_wa = REG_T4; wb_we = 1; wb_wa = REG_ZERO; wb_wd = 32'hBAD; #1;
      check("waw_stall", stall, 1);
      check("waw_drain_we", rfwe, 1);
      check("waw_drain_wa", rfwa, REG_T4);
      step(); step();

      // Reset with two results buffered; nothing stale may appear afterwards.
      issue(REG_T1); issue(REG_T2);
      idle(); wb_we = 1; wb_wa = REG_S2;
      llu_valid = 1; llu_wa = REG_T1; llu_wd = 32'h91; step();
      llu_wa = REG_T2; llu_wd = 32'h92; step();
      apply_reset();
      for (int i = 0; i < 4; i++) step();

      // Random legal traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1500) apply_reset();
         if (!(llu_valid && !m_acc)) begin
            if (outs.size() > 0 && $urandom_range(0, 2) != 0) begin
               int idx;
               idx = $urandom_range(0, outs.size() - 1);
               llu_wa = reg_enum'(outs[idx]);
               outs.delete(idx);
               llu_valid = 1; llu_wd = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
               llu_valid = 1; llu_wa = REG_ZERO; llu_wd = $urandom;
            end else begin
               llu_valid = 0;
            end
         end
         wb_we = ($urandom_range(0, 99) < 45);
         wb_wa = reg_enum'(5'($urandom_range(0, 31)));
         if (m_pend[wb_wa]) wb_wa = REG_ZERO;
         wb_wd = $urandom;
         llu_issue = ($urandom_range(0, 2) == 0);
         llu_issue_wa = reg_enum'(5'($urandom_range(0, 31)));
         dec_re1 = $urandom_range(0, 1); dec_ra1 = reg_enum'(5'($urandom_range(0, 31)));
         dec_re2 = $urandom_range(0, 1); dec_ra2 = reg_enum'(5'($urandom_range(0, 31)));
         dec_we  = $urandom_range(0, 1); dec_wa  = reg_enum'(5'($urandom_range(0, 31)));
         step();
         if (llu_issue && !m_stall && llu_issue_wa != REG_ZERO) outs.push_back(llu_issue_wa);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
